alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
Command-issue stage sitting directly upstream of the 16-bit multi-cycle ALU (add/sub/mul/logic, cs/rdy handshake).
- Accepts operand/opcode commands through a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's A/B/op/cs pins one command at a time, tracks the ALU busy/done handshake, and captures out/cout.
- Presents each result on a valid/ready output, with a timeout and illegal-opcode error path.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 64, max cycles waited in any ALU handshake phase before aborting
TW, 7, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  upstream command present
cmd_ready  out  1  FIFO not full
cmd_a  in  16  operand A
cmd_b  in  16  operand B
cmd_op  in  3  opcode: 0 add, 1 sub, 2 mul, 4-7 logic, 3 illegal
res_valid  out  1  result held
res_ready  in  1  downstream accepts result
res_out  out  16  ALU result
res_cout  out  1  ALU carry/borrow
res_op  out  3  opcode of this result
res_err  out  1  1 = timeout or illegal opcode
alu_a  out  16  to ALU A
alu_b  out  16  to ALU B
alu_op  out  3  to ALU op
alu_cs  out  1  to ALU cs
alu_out  in  16  from ALU out
alu_cout  in  1  from ALU cout
alu_rdy  in  1  from ALU rdy1 (1 = idle/done)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFO emptied; state IDLE.
  - Outputs cleared: alu_cs=0, alu_a/b/op=0, res_valid=0, res_out=0, res_cout=0, res_op=0, res_err=0, timeout counter=0.
  - cmd_ready=1 from the first cycle after reset.
  - Reset mid-transaction drops alu_cs immediately and discards the in-flight command and any held result.
- FIFO:
  - Push when cmd_valid&cmd_ready. Pop when the FSM leaves IDLE with a command.
  - Simultaneous push and pop while full is refused (cmd_ready=0 when full). Simultaneous push and pop otherwise keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
  - IDLE:
    - If FIFO non-empty and alu_rdy=1: pop, register alu_a/b/op from the head.
    - If op==3: go to HOLD with res_err=1, res_out=0, res_cout=0, res_op=3; no cs is issued.
    - Otherwise go to ISSUE.
    - If alu_rdy=0, stay in IDLE.
  - ISSUE: alu_cs=1 (registered), counter=0, go to WAIT_BUSY.
  - WAIT_BUSY:
    - alu_cs stays 1.
    - On alu_rdy=0 sampled: alu_cs=0, counter=0, go to WAIT_DONE.
    - If counter reaches TIMEOUT first: alu_cs=0, res_err=1, go to HOLD.
  - WAIT_DONE:
    - On alu_rdy=1 sampled: res_out<=alu_out, res_cout<=alu_cout, res_op<=alu_op, res_err<=0, go to HOLD.
    - On timeout: res_err=1, res_out=0, go to HOLD.
  - HOLD:
    - res_valid=1; result fields are stable.
    - On res_ready: res_valid=0, go to IDLE.
- alu_a/b/op are held stable from ISSUE through HOLD. They change only when IDLE pops a new command.
- Latency: command accepted into an empty FIFO -> alu_cs high 2 cycles later (IDLE pop, ISSUE). Result is valid 1 cycle after alu_rdy returns high.
- At most one command is in flight; results leave in command order.
- Counter saturates at TIMEOUT and never wraps.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_ILL=3, OP_LOG0..3=4..7
  - FSM state encoding constants
  - data width 16
- One natural sub-module: alu_cmd_fifo, a parameterised sync FIFO (35-bit entries: a, b, op) with full/empty.

Test Plan:
- Single add: push A=16'h0003, B=16'h0004, op=0; ALU model drops rdy 1 cycle after cs and returns it 3 cycles later -> alu_cs high for exactly the WAIT_BUSY window; res_valid with res_out=16'h0007, res_cout=0, res_err=0, res_op=0.
- Back-pressure and order: push 4 commands (sub 5-3, mul 3*4, add FFFF+1, logic op 4) with res_ready=0 -> cmd_ready=0 after the FIFO is full; releasing res_ready yields results 2, 12, 0000/cout=1, logic value, in that order.
- Illegal op: push op=3 -> alu_cs never asserts; result has res_err=1, res_out=0, res_op=3; the next legal command proceeds normally.
- Busy timeout: ALU model holds rdy=1 and ignores cs -> after TIMEOUT=64 cycles alu_cs drops, res_err=1; the FIFO then continues.
- Done timeout: ALU drops rdy and never raises it -> res_err=1 after 64 cycles in WAIT_DONE.
- Reset mid-op: assert rst during WAIT_DONE with 2 commands queued -> next cycle alu_cs=0, res_valid=0, cmd_ready=1, FIFO empty; no stale result appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, FSM encoding, command record.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    localparam int DW = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_ILL  = 3'd3;
    localparam logic [2:0] OP_LOG0 = 3'd4;
    localparam logic [2:0] OP_LOG1 = 3'd5;
    localparam logic [2:0] OP_LOG2 = 3'd6;
    localparam logic [2:0] OP_LOG3 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    // One queued command: 16 + 16 + 3 = 35 bits.
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Opcode 3 is the only hole in the ALU's opcode map.
    function automatic logic is_illegal(input logic [2:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO holding queued ALU commands; head visible combinationally.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: full refuses pushes (even with a same-cycle pop); pop ignored when empty.
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push_vld/dat   : write request and data; full : no room
//   pop            : consume head; pop_dat : head entry; empty : nothing queued
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage for the multi-cycle ALU: queues commands, runs the cs/rdy handshake, holds results.
// Latency: cmd accepted into empty FIFO -> alu_cs 2 cycles later; result valid 1 cycle after alu_rdy returns.
// Backpressure: cmd_ready drops when the FIFO is full; a held result blocks further issue until res_ready.
//   cmd_*  : upstream command valid/ready with operands and opcode
//   res_*  : result valid/ready with out, carry, opcode and error flag (timeout or illegal op)
//   alu_*  : ALU pins (a, b, op, cs out; out, cout, rdy in)
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic [2:0]    cmd_op,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_out,
    output logic          res_cout,
    output logic [2:0]    res_op,
    output logic          res_err,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    output logic          alu_cs,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_cout,
    input  logic          alu_rdy
);
    localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT);

    cmd_t          push_cmd, head_cmd;
    logic          fifo_full, fifo_empty, fifo_pop;

    state_e        state_q,     state_d;
    logic [DW-1:0] alu_a_q,     alu_a_d;
    logic [DW-1:0] alu_b_q,     alu_b_d;
    logic [2:0]    alu_op_q,    alu_op_d;
    logic          alu_cs_q,    alu_cs_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_out_q,   res_out_d;
    logic          res_cout_q,  res_cout_d;
    logic [2:0]    res_op_q,    res_op_d;
    logic          res_err_q,   res_err_d;
    logic [TW-1:0] cnt_q,       cnt_d;
    logic [TW-1:0] cnt_inc;

    assign push_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_valid),
        .push_dat (push_cmd),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .pop_dat  (head_cmd),
        .empty    (fifo_empty)
    );

    assign cmd_ready = !fifo_full;

    // Saturating increment; the abort fires on the cycle the count would reach TIMEOUT,
    // so each wait phase lasts at most TIMEOUT cycles.
    assign cnt_inc = (cnt_q == TO_CNT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_cs_d    = alu_cs_q;
        res_valid_d = res_valid_q;
        res_out_d   = res_out_q;
        res_cout_d  = res_cout_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && alu_rdy) begin
                    fifo_pop = 1'b1;
                    alu_a_d  = head_cmd.a;
                    alu_b_d  = head_cmd.b;
                    alu_op_d = head_cmd.op;
                    if (is_illegal(head_cmd.op)) begin
                        // Never reaches the ALU; report straight away.
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_out_d   = '0;
                        res_cout_d  = 1'b0;
                        res_op_d    = head_cmd.op;
                        state_d     = ST_HOLD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                alu_cs_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!alu_rdy) begin
                    alu_cs_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_CNT) begin
                        alu_cs_d    = 1'b0;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_out_d   = '0;
                        res_cout_d  = 1'b0;
                        res_op_d    = alu_op_q;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (alu_rdy) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    res_out_d   = alu_out;
                    res_cout_d  = alu_cout;
                    res_op_d    = alu_op_q;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_CNT) begin
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_out_d   = '0;
                        res_cout_d  = 1'b0;
                        res_op_d    = alu_op_q;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_cs_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_out_q   <= '0;
            res_cout_q  <= 1'b0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cs_q    <= alu_cs_d;
            res_valid_q <= res_valid_d;
            res_out_q   <= res_out_d;
            res_cout_q  <= res_cout_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cs    = alu_cs_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_out_q;
    assign res_cout  = res_cout_q;
    assign res_op    = res_op_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU on the alu_* pins.
// Latency: n/a.
// Backpressure: res_ready driven by the stimulus to exercise FIFO fill.
module tb_alu_issue;
    import alu_pkg::*;

    localparam int M_NORMAL = 0;  // rdy drops after cs, returns 3 cycles later
    localparam int M_IGNORE = 1;  // rdy stays 1, cs ignored
    localparam int M_HANG   = 2;  // rdy drops after cs, never returns

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [15:0]   cmd_a, cmd_b;
    logic [2:0]    cmd_op;
    logic          res_valid, res_ready;
    logic [15:0]   res_out;
    logic          res_cout;
    logic [2:0]    res_op;
    logic          res_err;
    logic [15:0]   alu_a, alu_b, alu_out;
    logic [2:0]    alu_op;
    logic          alu_cs, alu_cout, alu_rdy;

    int            total = 0;
    int            bad   = 0;
    int            mode  = M_NORMAL;
    int            cs_cycles = 0;
    int            dn_cycles = 0;
    int            busy_cnt  = 0;
    logic [16:0]   pend;

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(4), .TIMEOUT(64), .TW(7)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_cout(res_cout), .res_op(res_op), .res_err(res_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cs(alu_cs),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_rdy(alu_rdy)
    );

    function automatic logic [16:0] alu_calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), a - b};
            3'd2:    return {|p[31:16], p[15:0]};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            3'd7:    return {1'b0, ~a};
            default: return 17'd0;
        endcase
    endfunction

    // Monitors first, then the ALU model; all on the falling edge, away from the DUT's edge.
    always @(negedge clk) begin
        if (alu_cs) cs_cycles = cs_cycles + 1;
        if (!alu_rdy && !alu_cs && !res_valid) dn_cycles = dn_cycles + 1;
        if (rst) begin
            alu_rdy  = 1'b1;
            busy_cnt = 0;
        end else if (mode == M_IGNORE) begin
            alu_rdy  = 1'b1;
            busy_cnt = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
                alu_rdy  = 1'b1;
                alu_out  = pend[15:0];
                alu_cout = pend[16];
            end
        end else if (!alu_rdy) begin
            if (mode == M_NORMAL) alu_rdy = 1'b1;
        end else if (alu_cs) begin
            alu_rdy  = 1'b0;
            pend     = alu_calc(alu_op, alu_a, alu_b);
            busy_cnt = (mode == M_NORMAL) ? 3 : 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("push_wait", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [15:0] eo, input logic ec,
                           input logic [2:0] eop, input logic ee);
        int n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"},  32'(res_valid), 32'd1);
        chk({tag, "_out"},  32'(res_out),   32'(eo));
        chk({tag, "_cout"}, 32'(res_cout),  32'(ec));
        chk({tag, "_op"},   32'(res_op),    32'(eop));
        chk({tag, "_err"},  32'(res_err),   32'(ee));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        alu_rdy   = 1'b1;
        alu_out   = '0;
        alu_cout  = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_alu_cs",    32'(alu_cs),    32'd0);
        chk("rst_res_out",   32'(res_out),   32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        chk("rst_alu_op",    32'(alu_op),    32'd0);

        // Single add with exact issue and completion timing
        push(16'h0003, 16'h0004, OP_ADD);
        chk("add_cs_t1", 32'(alu_cs), 32'd0);
        @(negedge clk);
        chk("add_cs_t2", 32'(alu_cs), 32'd0);
        @(negedge clk);
        chk("add_cs_t3", 32'(alu_cs), 32'd1);
        @(negedge clk);
        chk("add_cs_t4", 32'(alu_cs), 32'd0);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("add_lat", 32'(n), 32'd3);
        chk("add_hold_a", 32'(alu_a), 32'h0003);
        chk("add_hold_b", 32'(alu_b), 32'h0004);
        collect("add", 16'h0007, 1'b0, OP_ADD, 1'b0);
        chk("add_release", 32'(res_valid), 32'd0);

        // Back-pressure and ordering
        push(16'h0005, 16'h0003, OP_SUB);
        push(16'h0003, 16'h0004, OP_MUL);
        push(16'hFFFF, 16'h0001, OP_ADD);
        push(16'hF0F0, 16'h0FF0, OP_LOG0);
        push(16'h0001, 16'h0001, OP_ADD);
        chk("bp_full", 32'(cmd_ready), 32'd0);
        // Offered while full: must be refused, so no sixth result may appear.
        cmd_valid = 1'b1;
        cmd_a     = 16'h0100;
        cmd_b     = 16'h0100;
        cmd_op    = OP_ADD;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_still_full", 32'(cmd_ready), 32'd0);
        collect("bp_sub", 16'h0002, 1'b0, OP_SUB,  1'b0);
        collect("bp_mul", 16'h000C, 1'b0, OP_MUL,  1'b0);
        collect("bp_ovf", 16'h0000, 1'b1, OP_ADD,  1'b0);
        collect("bp_log", 16'h00F0, 1'b0, OP_LOG0, 1'b0);
        collect("bp_add", 16'h0002, 1'b0, OP_ADD,  1'b0);
        repeat (20) @(negedge clk);
        chk("bp_no_extra", 32'(res_valid), 32'd0);
        chk("bp_drained",  32'(cmd_ready), 32'd1);

        // Illegal opcode
        base = cs_cycles;
        push(16'h0001, 16'h0002, OP_ILL);
        collect("ill", 16'h0000, 1'b0, OP_ILL, 1'b1);
        chk("ill_no_cs", 32'(cs_cycles - base), 32'd0);
        push(16'h000A, 16'h0014, OP_ADD);
        collect("ill_next", 16'h001E, 1'b0, OP_ADD, 1'b0);
        chk("ill_next_cs", 32'(cs_cycles - base), 32'd1);

        // Busy timeout, then the queue continues
        mode = M_IGNORE;
        base = cs_cycles;
        push(16'h0001, 16'h0002, OP_ADD);
        push(16'h0002, 16'h0003, OP_ADD);
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("bto_cs_len", 32'(cs_cycles - base), 32'd64);
        collect("bto", 16'h0000, 1'b0, OP_ADD, 1'b1);
        mode = M_NORMAL;
        collect("bto_next", 16'h0005, 1'b0, OP_ADD, 1'b0);

        // Done timeout
        mode = M_HANG;
        base = dn_cycles;
        push(16'h0009, 16'h0002, OP_SUB);
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("dto_len", 32'(dn_cycles - base), 32'd64);
        collect("dto", 16'h0000, 1'b0, OP_SUB, 1'b1);
        mode = M_NORMAL;
        repeat (3) @(negedge clk);

        // Reset during WAIT_DONE with two commands queued
        mode = M_HANG;
        push(16'h0011, 16'h0022, OP_ADD);
        push(16'h0033, 16'h0044, OP_ADD);
        push(16'h0055, 16'h0066, OP_ADD);
        n = 0;
        while (!alu_cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rmo_cs_seen", 32'(alu_cs), 32'd1);
        repeat (4) @(negedge clk);
        chk("rmo_cmd_ready_pre", 32'(cmd_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rmo_cs",        32'(alu_cs),    32'd0);
        chk("rmo_res_valid", 32'(res_valid), 32'd0);
        chk("rmo_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rmo_alu_a",     32'(alu_a),     32'd0);
        rst  = 1'b0;
        mode = M_NORMAL;
        base = cs_cycles;
        repeat (20) @(negedge clk);
        chk("rmo_no_issue", 32'(cs_cycles - base), 32'd0);
        chk("rmo_no_stale", 32'(res_valid), 32'd0);
        push(16'h0007, 16'h0008, OP_ADD);
        collect("rmo_next", 16'h000F, 1'b0, OP_ADD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
